// File: rtl/seq_feed_ctrl.sv
// Feeds a 10-bit pattern MSB-first to a sequence detector, one bit per DIV clocks, and counts its matches.
// Build option FEED_ROTATE_EN: rotate instead of zero-fill, so the loaded word is restored at done.
module seq_feed_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] word_in,
  input  logic       start,
  input  logic       abort,
  input  logic       match,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       det_clear,
  output logic       busy,
  output logic       done,
  output logic [3:0] match_count,
  output logic [9:0] shift_reg,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [25:0] PRE_LAST = 26'(DIV - 1);

  state_t      cur_state;
  state_t      nxt_state;
  logic [25:0] prescaler;
  logic [3:0]  bit_idx;
  logic        pending;
  logic        strobe;
  logic        count_hit;
  logic        fill_bit;

  assign strobe    = (cur_state == SHIFT) && (prescaler == PRE_LAST);
  // The detector's Moore output reflects a bit only in the cycle after its strobe.
  assign count_hit = pending && match && !abort && (match_count != 4'd15);

`ifdef FEED_ROTATE_EN
  assign fill_bit = shift_reg[9];
`else
  assign fill_bit = 1'b0;
`endif

  assign bit_out = shift_reg[9];
  assign state   = cur_state;

  always_comb begin
    nxt_state = cur_state;
    bit_valid = 1'b0;
    det_clear = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (cur_state)
      IDLE: begin
        if (start && !load) nxt_state = CLEAR;
      end
      CLEAR: begin
        busy      = 1'b1;
        det_clear = 1'b1;
        nxt_state = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        bit_valid = strobe;
        if (abort)                         nxt_state = IDLE;
        else if (strobe && bit_idx == 4'd9) nxt_state = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        done      = !abort;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
    // Strobes stay quiet while reset is held, even before the first reset edge.
    if (reset) begin
      bit_valid = 1'b0;
      det_clear = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      shift_reg   <= '0;
      match_count <= '0;
      prescaler   <= '0;
      bit_idx     <= '0;
      pending     <= 1'b0;
    end else begin
      pending <= strobe && !abort;
      if (count_hit) match_count <= match_count + 4'd1;
      case (cur_state)
        IDLE: begin
          if (load) shift_reg <= word_in;
        end
        CLEAR: begin
          if (!abort) begin
            match_count <= '0;
            prescaler   <= '0;
            bit_idx     <= '0;
          end
        end
        SHIFT: begin
          if (!abort) begin
            if (strobe) begin
              prescaler <= '0;
              shift_reg <= {shift_reg[8:0], fill_bit};
              bit_idx   <= bit_idx + 4'd1;
            end else begin
              prescaler <= prescaler + 26'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_feed_ctrl.md
SEQ_FEED_CTRL -- requirements
Module: seq_feed_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 4, meaning clock cycles per fed bit (legal range 1..2^26-1).
REQ-002 SHALL have port CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port load  in  1  capture word_in into shift_reg.
REQ-005 SHALL have port word_in  in  10  pattern word; fed MSB first.
REQ-006 SHALL have port start  in  1  begin a feed run.
REQ-007 SHALL have port abort  in  1  cancel the run in progress.
REQ-008 SHALL have port match  in  1  Moore match output of the downstream sequence detector.
REQ-009 SHALL have port bit_out  out  1  serial bit to the detector; equals shift_reg[9].
REQ-010 SHALL have port bit_valid  out  1  one-cycle strobe; the detector advances on it.
REQ-011 SHALL have port det_clear  out  1  one-cycle pulse returning the detector to its reset state.
REQ-012 SHALL have port busy  out  1  high in CLEAR, SHIFT and FINISH.
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port match_count  out  4  matches seen in the current or last run.
REQ-015 SHALL have port shift_reg  out  10  pattern register contents.
REQ-016 SHALL have port state  out  2  FSM state code.

Function
REQ-017 SHALL implement the FSM IDLE=0, CLEAR=1, SHIFT=2, FINISH=3.
REQ-018 In IDLE, load=1 SHALL copy word_in into shift_reg; start is ignored in that cycle (load has priority).
REQ-019 In IDLE, start=1 with load=0 SHALL move to CLEAR.
REQ-020 CLEAR SHALL last one cycle: det_clear=1, match_count cleared, 26-bit prescaler and 4-bit bit index cleared, then SHIFT.
REQ-021 In SHIFT, the prescaler SHALL increment each cycle; when prescaler==DIV-1, bit_valid=1, prescaler wraps to 0, shift_reg shifts left by one, and bit index increments.
REQ-022 First bit_valid SHALL occur DIV+1 cycles after start is sampled; later strobes follow at DIV-cycle spacing; DIV=1 gives a strobe every SHIFT cycle.
REQ-023 After the 10th bit_valid, the FSM SHALL enter FINISH for one cycle with done=1, then return to IDLE; start-to-done = 10*DIV+2 cycles.
REQ-024 A pending flag SHALL be set on each bit_valid; in the following cycle, pending && match SHALL increment match_count, saturating at 15.
REQ-025 match SHALL be ignored when pending=0.
REQ-026 load and start SHALL be ignored while busy=1.
REQ-027 abort=1 in CLEAR, SHIFT or FINISH SHALL return the FSM to IDLE next cycle: no done, no further bit_valid, match_count and shift_reg hold.
REQ-028 abort in IDLE SHALL have no effect; abort SHALL take priority over FINISH's done in the same cycle.
REQ-029 In SHIFT and FINISH the FSM SHALL sample match with zero added latency; bit_out and bit_valid SHALL be decoded from registered state.

Reset
REQ-030 reset=1 SHALL, on the clock edge and in any state, force: state=IDLE, shift_reg=0, match_count=0, prescaler=0, bit index=0, pending=0.
REQ-031 During and after reset: bit_valid=0, det_clear=0, busy=0, done=0, bit_out=0.
REQ-032 reset SHALL override load, start and abort in the same cycle.

Configuration
REQ-033 Macro FEED_ROTATE_EN SHALL select the shift fill bit.
REQ-034 FEED_ROTATE_EN defined: the shift SHALL rotate (shift_reg[9] wraps to bit 0), so shift_reg equals the loaded word at done.
REQ-035 FEED_ROTATE_EN undefined: the shift SHALL zero-fill, so shift_reg=0 at done.

Verification
REQ-036 DIV=4, load 10'b1100111000, start, reference detector for 1100111 -> bit_valid at cycles 5,9,...,41; done at cycle 42; match_count=1.
REQ-037 DIV=1, load 10'b1111111111 -> 10 consecutive bit_valid strobes; match_count=0; shift_reg ends 0 (macro off) or 10'h3FF (macro on).
REQ-038 Forced match=1 throughout a DIV=2 run -> match_count=10; match with pending=0 never counts.
REQ-039 abort asserted 2 cycles after the 3rd bit_valid -> IDLE next cycle; no done; no further bit_valid; match_count held.
REQ-040 load+start in the same IDLE cycle -> word captured, state stays IDLE; start while busy ignored; reset mid-SHIFT -> all REQ-030/031 values next cycle.
